gf_divide_four: RTL and testbench

- Sequential GF(2^4) divider: computes quotient = a · b⁻¹ in GF(16). It is the inverse operation of the team's GF(2^4) multiplier.
- The inverse b⁻¹ = b^14 is formed by square-and-multiply on a bit-serial shift-and-add multiplier datapath, one multiplier bit per clock.
- Sits beside the GF add/multiply blocks in the GField library and feeds higher-level field arithmetic, e.g. syndrome and erasure solvers.
- Valid/ready handshake on both input and output; one operation in flight.

---
 rtl/gf4_pkg.sv | 31 +++
 rtl/gf_mul_step.sv | 20 ++
 rtl/gf_divide_four.sv | 144 ++++++++++++++
 tb/tb_gf_divide_four.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/gf4_pkg.sv
// rtl/gf4_pkg.sv - shared GF(2^4) types and constants for the GField divider
package gf4_pkg;

  localparam int GF_WIDTH = 4;
  localparam logic [GF_WIDTH-1:0] GF_DEFAULT_POLY = 4'b0011;
  localparam int GF_OP_COUNT = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SQUARE = 2'd0,
    MUL_B  = 2'd1,
    MUL_A  = 2'd2
  } op_sel_t;

  // Square-and-multiply schedule for b^14 followed by the final multiply by a.
  function automatic op_sel_t op_select(input logic [2:0] op);
    op_sel_t sel;
    case (op)
      3'd1, 3'd3: sel = MUL_B;
      3'd5:       sel = MUL_A;
      default:    sel = SQUARE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/gf_mul_step.sv
// rtl/gf_mul_step.sv - combinational MSB-first Horner step of a GF(2^4) serial multiplier
module gf_mul_step
  import gf4_pkg::*;
#(
  parameter logic [GF_WIDTH-1:0] POLY = GF_DEFAULT_POLY
) (
  input  logic [GF_WIDTH-1:0] p,
  input  logic [GF_WIDTH-1:0] x,
  input  logic                mbit,
  output logic [GF_WIDTH-1:0] y
);

  logic [GF_WIDTH-1:0] xt;

  always_comb begin
    xt = {p[GF_WIDTH-2:0], 1'b0} ^ (p[GF_WIDTH-1] ? POLY : '0);
    y  = xt ^ (mbit ? x : '0);
  end

endmodule

// File: rtl/gf_divide_four.sv
// rtl/gf_divide_four.sv - sequential GF(2^4) divider, quotient = a * b^-1 (optional GF_DIV_FAST_ONE_EN)
module gf_divide_four
  import gf4_pkg::*;
#(
  parameter logic [GF_WIDTH-1:0] POLY = GF_DEFAULT_POLY
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [GF_WIDTH-1:0] a,
  input  logic [GF_WIDTH-1:0] b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [GF_WIDTH-1:0] quotient,
  output logic                div_by_zero
);

  localparam logic [2:0] LAST_OP = 3'(GF_OP_COUNT - 1);

  state_t              state, state_d;
  logic [GF_WIDTH-1:0] a_r, a_d;
  logic [GF_WIDTH-1:0] b_r, b_d;
  logic [GF_WIDTH-1:0] acc, acc_d;
  logic [GF_WIDTH-1:0] p, p_d;
  logic [2:0]          op, op_d;
  logic [1:0]          bitc, bit_d;
  logic [GF_WIDTH-1:0] q_d;
  logic                dz_d;

  op_sel_t             sel;
  logic [GF_WIDTH-1:0] m;
  logic [GF_WIDTH-1:0] step_y;

  // x is always acc; only the bit-serial operand m changes with the schedule.
  always_comb begin
    sel = op_select(op);
    case (sel)
      MUL_B:   m = b_r;
      MUL_A:   m = a_r;
      default: m = acc;
    endcase
  end

  gf_mul_step #(.POLY(POLY)) u_step (
    .p    (p),
    .x    (acc),
    .mbit (m[bitc]),
    .y    (step_y)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    state_d = state;
    a_d     = a_r;
    b_d     = b_r;
    acc_d   = acc;
    p_d     = p;
    op_d    = op;
    bit_d   = bitc;
    q_d     = quotient;
    dz_d    = div_by_zero;

    case (state)
      IDLE: begin
        if (in_valid) begin
          a_d = a;
          b_d = b;
          if (b == '0) begin
            q_d     = '0;
            dz_d    = 1'b1;
            state_d = DONE;
          end
`ifdef GF_DIV_FAST_ONE_EN
          else if (b == 4'b0001) begin
            q_d     = a;
            dz_d    = 1'b0;
            state_d = DONE;
          end
`endif
          else begin
            acc_d   = b;
            p_d     = '0;
            op_d    = 3'd0;
            bit_d   = 2'd3;
            state_d = MUL;
          end
        end
      end

      MUL: begin
        p_d = step_y;
        if (bitc == 2'd0) begin
          acc_d = step_y;
          p_d   = '0;
          bit_d = 2'd3;
          if (op == LAST_OP) begin
            op_d    = 3'd0;
            q_d     = step_y;
            dz_d    = 1'b0;
            state_d = DONE;
          end else begin
            op_d = op + 3'd1;
          end
        end else begin
          bit_d = bitc - 2'd1;
        end
      end

      DONE: begin
        if (out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      a_r         <= '0;
      b_r         <= '0;
      acc         <= '0;
      p           <= '0;
      op          <= 3'd0;
      bitc        <= 2'd0;
      quotient    <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state       <= state_d;
      a_r         <= a_d;
      b_r         <= b_d;
      acc         <= acc_d;
      p           <= p_d;
      op          <= op_d;
      bitc        <= bit_d;
      quotient    <= q_d;
      div_by_zero <= dz_d;
    end
  end

endmodule

// File: tb/tb_gf_divide_four.sv
// tb/tb_gf_divide_four.sv - self-checking bench for gf_divide_four (honours GF_DIV_FAST_ONE_EN)
module tb_gf_divide_four;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a;
  logic [3:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] quotient;
  logic       div_by_zero;

  int checks = 0;
  int errors = 0;

  gf_divide_four dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Carry-less product, reduced by x^4 + x + 1 (0x13).
  function automatic int ref_mul(input int x, input int y);
    int prod = 0;
    for (int i = 0; i < 4; i++)
      if (((y >> i) & 1) != 0) prod = prod ^ (x << i);
    for (int k = 6; k >= 4; k--)
      if (((prod >> k) & 1) != 0) prod = prod ^ (19 << (k - 4));
    return prod & 15;
  endfunction

  // The quotient is whatever field element times b gives back a.
  function automatic int ref_div(input int x, input int y);
    if (y == 0) return 0;
    for (int q = 0; q < 16; q++)
      if (ref_mul(q, y) == x) return q;
    return -1;
  endfunction

  function automatic int ref_latency(input int y);
    if (y == 0) return 0;
`ifdef GF_DIV_FAST_ONE_EN
    if (y == 1) return 0;
`endif
    return 24;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full transaction: accept, wait for result, hold off out_ready for stall cycles, release.
  task automatic run_op(input logic [3:0] ta, input logic [3:0] tb_v, input int stall,
                        input bit full);
    int g;
    int lat;
    logic [3:0] q0;
    logic dz0;
    g = 0;
    while (!in_ready && g < 50) begin
      @(posedge clk); #1; g++;
    end
    chk("in_ready_before_accept", in_ready, 1'b1);
    in_valid  = 1'b1;
    a         = ta;
    b         = tb_v;
    out_ready = (stall == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a        = 4'($urandom);
    b        = 4'($urandom);
    lat      = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    chk($sformatf("out_valid a=%0d b=%0d", ta, tb_v), out_valid, 1'b1);
    chk($sformatf("quotient a=%0d b=%0d", ta, tb_v), quotient, 32'(ref_div(ta, tb_v)));
    chk($sformatf("div_by_zero a=%0d b=%0d", ta, tb_v), div_by_zero, tb_v == 4'd0);
    chk($sformatf("latency a=%0d b=%0d", ta, tb_v), lat, 32'(ref_latency(tb_v)));
    if (full) begin
      chk($sformatf("product a=%0d b=%0d", ta, tb_v), 32'(ref_mul(quotient, tb_v)),
          (tb_v == 4'd0) ? 32'd0 : 32'(ta));
      chk("in_ready_busy", in_ready, 1'b0);
    end
    q0  = quotient;
    dz0 = div_by_zero;
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      @(posedge clk); #1;
      chk("hold_out_valid", out_valid, 1'b1);
      chk("hold_quotient", quotient, q0);
      chk("hold_div_by_zero", div_by_zero, dz0);
      chk("hold_in_ready", in_ready, 1'b0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("release_out_valid", out_valid, 1'b0);
    chk("release_in_ready", in_ready, 1'b1);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    a         = 4'd0;
    b         = 4'd0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_quotient", quotient, 4'd0);
    chk("reset_div_by_zero", div_by_zero, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op(4'd5, 4'd2, 0, 1'b1);
    chk("ref_5_div_2", 32'(ref_div(5, 2)), 32'hB);
    run_op(4'd1, 4'd3, 0, 1'b1);
    run_op(4'd7, 4'd7, 0, 1'b1);
    run_op(4'd0, 4'd9, 0, 1'b1);
    run_op(4'd6, 4'd0, 0, 1'b1);
    run_op(4'd3, 4'd5, 10, 1'b1);
    run_op(4'd9, 4'd1, 2, 1'b1);

    // Asynchronous reset landing in op 2 of the schedule.
    in_valid = 1'b1;
    a        = 4'd12;
    b        = 4'd6;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("async_rst_in_ready", in_ready, 1'b1);
    chk("async_rst_out_valid", out_valid, 1'b0);
    chk("async_rst_quotient", quotient, 4'd0);
    chk("async_rst_div_by_zero", div_by_zero, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_idle", out_valid, 1'b0);
    run_op(4'd5, 4'd2, 0, 1'b1);

    for (int ia = 0; ia < 16; ia++)
      for (int ib = 1; ib < 16; ib++)
        run_op(4'(ia), 4'(ib), 0, 1'b0);

    for (int r = 0; r < 30; r++)
      run_op(4'($urandom), 4'($urandom), int'($urandom_range(0, 4)), 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
